rv32_cpu_cp_div_radix: RTL and testbench
========================================

// Module: rv32_cpu_cp_div_radix
// PURPOSE
//   Iterative integer divider co-processor for the CPU ALU, executing RISC-V M-extension DIV/DIVU/REM/REMU.
//   Restoring division, retiring BITS_PER_CYCLE quotient bits per clock, with parametrised width.
//   Optional early completion on divide-by-zero; abort on CPU trap.
//   Sits beside the multiplier co-processor; started by the ALU and polled through o_valid.
// PARAMETERS
//   XLEN            32  operand/result width in bits
//   BITS_PER_CYCLE  1   quotient bits per iteration; legal values 1, 2, 4; must divide XLEN
//   FAST_ZERO       1   1 = rs2==0 skips the iteration phase
// PORTS
//   i_clk       in   1     clock, all state on rising edge
//   i_rstn      in   1     asynchronous active-low reset
//   i_start     in   1     start pulse; sampled only in IDLE
//   i_cpu_trap  in   1     abort request
//   i_div_op    in   3     100 DIV, 101 DIVU, 110 REM, 111 REMU
//   i_rs1       in   XLEN  dividend, sampled with i_start
//   i_rs2       in   XLEN  divisor, sampled with i_start
//   o_res       out  XLEN  registered result; held until the next accepted start
//   o_valid     out  1     one-cycle pulse: o_res is valid
//   o_busy      out  1     high in every state except IDLE
// BEHAVIOUR
//   Reset (async, i_rstn=0):
//     state=IDLE; o_res=0, o_valid=0, o_busy=0.
//     Datapath registers cleared. A reset mid-operation discards the operation silently.
//   Iteration count: N = XLEN/BITS_PER_CYCLE. Iteration counter width = clog2(N).
//   FSM states: IDLE, BUSY, FIX, READY.
//     IDLE -> BUSY on i_start. Latch op, sign_mod, |rs1| into quotient, |rs2|; remainder=0; cnt=N-1.
//     IDLE -> FIX instead of BUSY when FAST_ZERO=1 and i_rs2==0.
//     BUSY: each cycle performs BITS_PER_CYCLE chained restoring steps.
//       Each step: trial = {rem, q_msb} - divisor (XLEN+1 bits).
//       If the trial is non-negative, rem=trial[XLEN-1:0] and q_lsb=1; else shift only and q_lsb=0.
//       Exit to FIX when cnt==0 after the step; otherwise cnt--.
//     FIX: o_res <= sign_mod ? -sel : sel. sel = remainder for REM/REMU, quotient for DIV/DIVU.
//     READY: o_valid=1 for exactly this cycle, then IDLE.
//   Latency: valid in cycle N+2 after the i_start sample edge (N BUSY, 1 FIX, READY); FAST_ZERO path: 2.
//   Signedness: rs1 and rs2 are negated only when negative and the op is DIV or REM.
//     sign_mod(DIV) = (rs1[msb]^rs2[msb]) & (rs2!=0).
//     sign_mod(REM) = rs1[msb].
//     sign_mod = 0 for unsigned ops.
//   Divide-by-zero (either path): DIV/DIVU give all ones; REM/REMU give rs1 unchanged.
//     The FAST_ZERO path loads these values directly in FIX.
//   Signed overflow: DIV of -2^(XLEN-1) by -1 gives -2^(XLEN-1); REM gives 0. No special-case logic.
//   i_cpu_trap in BUSY or FIX: next state IDLE; o_valid is not asserted; o_res keeps its previous value.
//     A trap in READY has no effect; the pulse completes.
//   i_start outside IDLE is ignored. i_start together with i_cpu_trap in IDLE: trap wins, no start.
//   Operand inputs may change freely after the start cycle.
// TESTING
//   DIVU 100/7, BITS_PER_CYCLE=1 -> o_valid exactly at cycle 34 after start, o_res=14; REMU -> 2.
//   DIV -7/2 and REM -7/2, all legal BITS_PER_CYCLE -> 0xFFFFFFFD and 0xFFFFFFFF; latency 18 (BPC=2), 10 (BPC=4).
//   DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0x00000000.
//   rs2=0, rs1=0x1234: DIV -> 0xFFFFFFFF, REMU -> 0x1234.
//     FAST_ZERO=1 gives valid at cycle 2; FAST_ZERO=0 gives valid at cycle N+2.
//   i_cpu_trap at BUSY cycle 5 -> no o_valid, o_busy low next cycle; a new start then completes normally.
//   i_rstn low mid-BUSY -> o_valid/o_busy/o_res=0 immediately; i_start pulsed during BUSY -> ignored, first result unaffected.

Source files
------------

// File: rtl/rv32_cpu_cp_div_radix_if.sv
// Handshake bundle between the ALU and the divider co-processor.
// Ports: i_start/i_cpu_trap/i_div_op/i_rs1/i_rs2 (ALU -> divider), o_res/o_valid/o_busy (divider -> ALU).
// master = ALU side, slave = divider side.
interface rv32_cpu_cp_div_radix_if #(
  parameter int XLEN = 32
);
  logic            i_start;
  logic            i_cpu_trap;
  logic [2:0]      i_div_op;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic [XLEN-1:0] o_res;
  logic            o_valid;
  logic            o_busy;

  modport master (
    output i_start, i_cpu_trap, i_div_op, i_rs1, i_rs2,
    input  o_res, o_valid, o_busy
  );

  modport slave (
    input  i_start, i_cpu_trap, i_div_op, i_rs1, i_rs2,
    output o_res, o_valid, o_busy
  );
endinterface

// File: rtl/rv32_cpu_cp_div_radix.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, BITS_PER_CYCLE quotient bits per clock.
// Latency: o_valid in cycle XLEN/BITS_PER_CYCLE+2 after the start sample edge; divide-by-zero fast path: 2.
// No backpressure: i_start is ignored while o_busy; i_cpu_trap aborts in BUSY/FIX; result is polled via o_valid.
// Ports: i_clk, i_rstn (async active-low); bus (slave modport) carries start/trap/op/operands in,
//        o_res (held until overwritten), o_valid (one-cycle pulse), o_busy (high outside IDLE) out.
module rv32_cpu_cp_div_radix #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit FAST_ZERO      = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  rv32_cpu_cp_div_radix_if.slave   bus
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_READY} state_t;

  state_t            state_q, state_d;
  logic              is_rem_q, is_rem_d;
  logic              sign_mod_q, sign_mod_d;
  logic              zero_q, zero_d;       // fast divide-by-zero path taken
  logic [XLEN-1:0]   quo_q, quo_d;         // dividend shifts out, quotient shifts in
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  // Operand decode for the start cycle
  logic              is_signed;
  logic              rs1_neg, rs2_neg, rs2_zero;
  logic [XLEN-1:0]   rs1_abs, rs2_abs;

  assign is_signed = bus.i_div_op[2] & ~bus.i_div_op[0];
  assign rs1_neg   = is_signed & bus.i_rs1[XLEN-1];
  assign rs2_neg   = is_signed & bus.i_rs2[XLEN-1];
  assign rs2_zero  = (bus.i_rs2 == '0);
  assign rs1_abs   = rs1_neg ? (~bus.i_rs1 + XLEN'(1)) : bus.i_rs1;
  assign rs2_abs   = rs2_neg ? (~bus.i_rs2 + XLEN'(1)) : bus.i_rs2;

  // Chained restoring steps for one clock
  logic [XLEN-1:0]   step_rem, step_quo;
  logic [XLEN:0]     shifted, trial;
  logic [XLEN-1:0]   sel_val;

  always_comb begin
    state_d    = state_q;
    is_rem_d   = is_rem_q;
    sign_mod_d = sign_mod_q;
    zero_d     = zero_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;

    step_rem = rem_q;
    step_quo = quo_q;
    shifted  = '0;
    trial    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = {step_rem, step_quo[XLEN-1]};
      trial   = shifted - {1'b0, step_div()};
      // trial[XLEN] set means the subtraction went negative: restore
      if (!trial[XLEN]) step_rem = trial[XLEN-1:0];
      else              step_rem = shifted[XLEN-1:0];
      step_quo = {step_quo[XLEN-2:0], ~trial[XLEN]};
    end

    // On the fast zero path quo_q still holds |rs1|, and sign_mod restores the original rs1 for REM
    if (zero_q) sel_val = is_rem_q ? quo_q : '1;
    else        sel_val = is_rem_q ? rem_q : quo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start && !bus.i_cpu_trap) begin
          is_rem_d   = bus.i_div_op[1];
          sign_mod_d = bus.i_div_op[1] ? rs1_neg : ((rs1_neg ^ rs2_neg) & ~rs2_zero);
          quo_d      = rs1_abs;
          div_d      = rs2_abs;
          rem_d      = '0;
          cnt_d      = CNT_W'(N - 1);
          zero_d     = FAST_ZERO && rs2_zero;
          state_d    = (FAST_ZERO && rs2_zero) ? S_FIX : S_BUSY;
          busy_d     = 1'b1;
        end
      end
      S_BUSY: begin
        if (bus.i_cpu_trap) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        if (bus.i_cpu_trap) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          res_d   = sign_mod_q ? (~sel_val + XLEN'(1)) : sel_val;
          valid_d = 1'b1;
          state_d = S_READY;
        end
      end
      S_READY: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  function automatic logic [XLEN-1:0] step_div();
    return div_q;
  endfunction

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      is_rem_q   <= 1'b0;
      sign_mod_q <= 1'b0;
      zero_q     <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_rem_q   <= is_rem_d;
      sign_mod_q <= sign_mod_d;
      zero_q     <= zero_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_res   = res_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_rv32_cpu_cp_div_radix.sv
// Bench for the divider: four instances (BPC 1/2/4 with fast zero, BPC 1 without) share one stimulus.
// Expected results and completion cycles are queued at start and matched when each o_valid pulses.
module tb_rv32_cpu_cp_div_radix;
  localparam int ND = 4;
  localparam int BPC_T [ND] = '{1, 2, 4, 1};
  localparam bit FZ_T  [ND] = '{1'b1, 1'b1, 1'b1, 1'b0};

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        trap = 1'b0;
  logic [2:0]  op = OP_DIV;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;

  logic        vld [ND];
  logic        bsy [ND];
  logic [31:0] res [ND];
  logic [31:0] last_res [ND];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] dut;
    logic [31:0] res;
    logic [31:0] cyc;
    logic [2:0]  op;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    rv32_cpu_cp_div_radix_if #(.XLEN(32)) bus ();
    assign bus.i_start    = start;
    assign bus.i_cpu_trap = trap;
    assign bus.i_div_op   = op;
    assign bus.i_rs1      = rs1;
    assign bus.i_rs2      = rs2;
    rv32_cpu_cp_div_radix #(
      .XLEN(32), .BITS_PER_CYCLE(BPC_T[g]), .FAST_ZERO(FZ_T[g])
    ) u_dut (
      .i_clk (clk),
      .i_rstn(rstn),
      .bus   (bus)
    );
    assign vld[g] = bus.o_valid;
    assign bsy[g] = bus.o_busy;
    assign res[g] = bus.o_res;
  end

  function automatic logic [31:0] model(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sdv;
    sa  = a;
    sdv = b;
    case (o)
      OP_DIV:  if (b == 0) return '1;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
               else return sa / sdv;
      OP_DIVU: if (b == 0) return '1; else return a / b;
      OP_REM:  if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
               else return sa % sdv;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int lat(int d, logic [31:0] b);
    if (FZ_T[d] && b == 0) return 2;
    return 32 / BPC_T[d] + 2;
  endfunction

  function automatic bit any_busy();
    for (int d = 0; d < ND; d++) if (bsy[d] !== 1'b0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: advance to the falling edge, then match any o_valid pulses against the scoreboard
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < ND; d++) begin
      if (!rstn) last_res[d] = '0;
      if (vld[d] === 1'b1) begin
        int idx;
        idx = -1;
        for (int k = 0; k < sb.size(); k++) if (idx < 0 && sb[k].dut == d) idx = k;
        n_checks++;
        assert (idx >= 0) else begin
          n_fail++;
          $error("FAIL unexpected_valid dut%0d cyc %0d: o_valid=1 required 0", d, cyc);
        end
        if (idx >= 0) begin
          exp_t e;
          e = sb[idx];
          sb.delete(idx);
          n_checks++;
          assert (res[d] === e.res) else begin
            n_fail++;
            $error("FAIL result dut%0d op %b: o_res=%h required %h", d, e.op, res[d], e.res);
          end
          n_checks++;
          assert (cyc === int'(e.cyc)) else begin
            n_fail++;
            $error("FAIL latency dut%0d op %b: valid at cycle %0d required %0d", d, e.op, cyc, e.cyc);
          end
          last_res[d] = e.res;
        end
      end
    end
  endtask

  // Present a start for one cycle; expectations queued for duts selected by mask
  task automatic do_op(logic [2:0] o, logic [31:0] a, logic [31:0] b, logic [ND-1:0] mask);
    int s;
    s     = cyc;
    op    = o;
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    for (int d = 0; d < ND; d++)
      if (mask[d]) sb.push_back('{dut: 32'(d), res: model(o, a, b), cyc: 32'(s + lat(d, b)), op: o});
    tick();
    start = 1'b0;
    rs1   = $urandom;   // operands may change freely after the start cycle
    rs2   = $urandom;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((any_busy() || sb.size() != 0) && t < 200) begin
      tick();
      t++;
    end
    n_checks++;
    assert (t < 200) else begin
      n_fail++;
      $error("FAIL timeout: busy/pending still outstanding after %0d cycles, required completion", t);
    end
  endtask

  task automatic check_idle_outputs(string tag, bit check_res, bit res_zero);
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      assert (bsy[d] === 1'b0) else begin
        n_fail++;
        $error("FAIL %s busy dut%0d: o_busy=%b required 0", tag, d, bsy[d]);
      end
      n_checks++;
      assert (vld[d] === 1'b0) else begin
        n_fail++;
        $error("FAIL %s valid dut%0d: o_valid=%b required 0", tag, d, vld[d]);
      end
      if (check_res) begin
        n_checks++;
        assert (res[d] === (res_zero ? 32'h0 : last_res[d])) else begin
          n_fail++;
          $error("FAIL %s res dut%0d: o_res=%h required %h", tag, d, res[d],
                 res_zero ? 32'h0 : last_res[d]);
        end
      end
    end
  endtask

  initial begin
    int s;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rstn = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset", 1'b1, 1'b1);
    rstn = 1'b1;
    tick();

    // Directed arithmetic
    do_op(OP_DIVU, 32'd100, 32'd7, 4'hF);                 wait_done();
    do_op(OP_REMU, 32'd100, 32'd7, 4'hF);                 wait_done();
    do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 4'hF);           wait_done();
    do_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 4'hF);           wait_done();
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 4'hF);   wait_done();
    do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 4'hF);   wait_done();
    do_op(OP_DIV,  32'h0000_1234, 32'h0, 4'hF);           wait_done();
    do_op(OP_REMU, 32'h0000_1234, 32'h0, 4'hF);           wait_done();
    do_op(OP_REM,  32'hFFFF_FFF0, 32'h0, 4'hF);           wait_done();
    do_op(OP_DIV,  32'hFFFF_FFF0, 32'h0, 4'hF);           wait_done();
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'h1, 4'hF);           wait_done();
    do_op(OP_REM,  32'd100, 32'hFFFF_FFF9, 4'hF);         wait_done();

    // Random operands against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      ro = 3'b100 | 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 6) rb = ~rb + 32'd1;
      do_op(ro, ra, rb, 4'hF);
      wait_done();
    end

    // Trap in BUSY cycle 5: aborted silently, o_res kept
    s = cyc;
    do_op(OP_DIVU, 32'd1000, 32'd3, 4'h0);
    while (cyc < s + 5) tick();
    trap = 1'b1;
    tick();
    trap = 1'b0;
    check_idle_outputs("trap_busy", 1'b1, 1'b0);
    tick();
    do_op(OP_DIV, 32'd1000, 32'hFFFF_FFFD, 4'hF);         wait_done();

    // Start during BUSY is ignored
    do_op(OP_REMU, 32'd1000, 32'd7, 4'hF);
    tick();
    op = OP_DIVU; rs1 = 32'd55; rs2 = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();

    // Start together with trap in IDLE: no start
    op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1; trap = 1'b1;
    tick();
    start = 1'b0; trap = 1'b0;
    check_idle_outputs("start_trap_idle", 1'b1, 1'b0);
    tick();

    // Trap while fast-zero instances sit in READY: their pulse completes, the slow instance aborts
    do_op(OP_DIV, 32'h0000_1234, 32'h0, 4'b0111);
    tick();
    trap = 1'b1;
    tick();
    trap = 1'b0;
    check_idle_outputs("trap_ready", 1'b1, 1'b0);
    wait_done();

    // Reset mid-BUSY clears everything at once
    do_op(OP_DIVU, 32'd1000, 32'd3, 4'h0);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check_idle_outputs("reset_busy", 1'b1, 1'b1);
    tick();
    rstn = 1'b1;
    tick();
    do_op(OP_REMU, 32'd1000, 32'd3, 4'hF);                wait_done();

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: %0d results still pending, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
